// File: rtl/block_mem_pkg.sv
// Shared types, default geometry and helpers for the block-memory responder.
package block_mem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp,
        StWaitRel
    } state_e;

    // Default geometry: 2 KiB of 8-bit bytes in 32-byte blocks, 4-edge latency.
    localparam int unsigned DEF_ADDR_WIDTH = 11;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_BLOCK_SIZE = 32;
    localparam int unsigned DEF_LATENCY    = 4;

    // Widest byte lane the reset pattern helper can produce.
    localparam int unsigned MAX_DATA_WIDTH = 32;

    // Number of byte-offset bits inside a block.
    function automatic int unsigned offset_bits(input int unsigned block_size);
        return $clog2(block_size);
    endfunction

    // Number of blocks in a 2^addr_width byte space.
    function automatic int unsigned num_blocks(input int unsigned addr_width,
                                               input int unsigned block_size);
        return (1 << addr_width) / block_size;
    endfunction

    // Latency counter width; wide enough to hold latency-1.
    function automatic int unsigned cnt_w(input int unsigned latency);
        return $clog2(latency) + 1;
    endfunction

    // Reset contents: each byte holds the low data_width bits of its own address.
    function automatic logic [MAX_DATA_WIDTH-1:0] init_byte(input logic [31:0]   addr,
                                                            input int unsigned data_width);
        logic [MAX_DATA_WIDTH-1:0] mask;
        if (data_width >= MAX_DATA_WIDTH) begin
            mask = '1;
        end else begin
            mask = (MAX_DATA_WIDTH'(1) << data_width) - MAX_DATA_WIDTH'(1);
        end
        return addr & mask;
    endfunction

endpackage

// File: rtl/block_mem_responder_store.sv
// Block array: NUM_BLOCKS x BLOCK_SIZE bytes, synchronous reset-init to the address
// pattern, one synchronous write port and one combinational read port.
module block_store
    import block_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned IDX_W      = ADDR_WIDTH - offset_bits(BLOCK_SIZE)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  we_i,
    input  logic [IDX_W-1:0]                      waddr_i,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]                      raddr_i,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned NUM_BLOCKS = num_blocks(ADDR_WIDTH, BLOCK_SIZE);

    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_d [NUM_BLOCKS];
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_q [NUM_BLOCKS];

    // Next array contents: a single whole-block write per edge.
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Array state; reset reloads every byte with its address pattern.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                for (int i = 0; i < BLOCK_SIZE; i++) begin
                    mem_q[b][i] <= DATA_WIDTH'(init_byte(32'(b * BLOCK_SIZE + i), DATA_WIDTH));
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/block_mem_responder.sv
// Latency-configurable block-memory responder with a four-phase request handshake.
// Requests are captured in IDLE, committed after LATENCY edges, answered with a
// one-cycle ready/hit strobe, and must be released before the next is accepted.
module block_mem_responder
    import block_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned LATENCY    = DEF_LATENCY
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  read,
    input  logic                                  write,
    input  logic [ADDR_WIDTH-1:0]                 addr,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] data_in,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] data_out,
    output logic                                  hit,
    output logic                                  ready,
    output logic                                  busy
);

    localparam int unsigned OFFSET_BITS = offset_bits(BLOCK_SIZE);
    localparam int unsigned IDX_W       = ADDR_WIDTH - OFFSET_BITS;
    localparam int unsigned CNT_W       = cnt_w(LATENCY);

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;

    state_e            state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [IDX_W-1:0]  idx_d, idx_q;
    blk_t              wdata_d, wdata_q;
    logic              op_rd_d, op_rd_q;
    logic              op_wr_d, op_wr_q;
    blk_t              data_out_d, data_out_q;
    logic              ready_d, ready_q;
    logic              hit_d, hit_q;
    logic              busy_d, busy_q;

    logic              store_we;
    blk_t              store_rdata;
    logic              unused_offset;

    // Offset bits select a byte within the block and play no part in a block access.
    assign unused_offset = ^addr[OFFSET_BITS-1:0];

    block_store #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .IDX_W      (IDX_W)
    ) u_store (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .we_i    (store_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (idx_q),
        .rdata_o (store_rdata)
    );

    // Next-state, capture, commit and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        op_rd_d    = op_rd_q;
        op_wr_d    = op_wr_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        hit_d      = 1'b0;
        store_we   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (read || write) begin
                    idx_d   = addr[ADDR_WIDTH-1:OFFSET_BITS];
                    wdata_d = data_in;
                    op_rd_d = read;
                    op_wr_d = write;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    // Write lands this edge; a combined read must see the new block.
                    store_we = op_wr_q;
                    if (op_rd_q) begin
                        data_out_d = op_wr_q ? wdata_q : store_rdata;
                    end
                    ready_d = 1'b1;
                    hit_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                state_d = (read || write) ? StWaitRel : StIdle;
            end
            StWaitRel: begin
                if (!read && !write) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // FSM and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            op_rd_q    <= 1'b0;
            op_wr_q    <= 1'b0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            hit_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            op_rd_q    <= op_rd_d;
            op_wr_q    <= op_wr_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            hit_q      <= hit_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out = data_out_q;
    assign ready    = ready_q;
    assign hit      = hit_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// Randomized self-checking bench for block_mem_responder against a block-level model.
module tb_block_mem_responder;

    localparam int unsigned AW  = 11;
    localparam int unsigned DW  = 8;
    localparam int unsigned BS  = 32;
    localparam int unsigned LAT = 4;
    localparam int unsigned NB  = (1 << AW) / BS;

    typedef logic [BS-1:0][DW-1:0] blk_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;

    logic          a_read  = 1'b0;
    logic          a_write = 1'b0;
    logic [AW-1:0] a_addr  = '0;
    blk_t          a_din   = '0;
    blk_t          a_dout;
    logic          a_hit, a_ready, a_busy;

    logic          b_read  = 1'b0;
    logic          b_write = 1'b0;
    logic [AW-1:0] b_addr  = '0;
    blk_t          b_din   = '0;
    blk_t          b_dout;
    logic          b_hit, b_ready, b_busy;

    int            n_tests = 0;
    int            n_fail  = 0;

    blk_t          ref_blk [NB];
    blk_t          exp_dout;

    always #5 clk = ~clk;

    block_mem_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BLOCK_SIZE (BS),
        .LATENCY    (LAT)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .read     (a_read),
        .write    (a_write),
        .addr     (a_addr),
        .data_in  (a_din),
        .data_out (a_dout),
        .hit      (a_hit),
        .ready    (a_ready),
        .busy     (a_busy)
    );

    block_mem_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BLOCK_SIZE (BS),
        .LATENCY    (1)
    ) u_dut_lat1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .read     (b_read),
        .write    (b_write),
        .addr     (b_addr),
        .data_in  (b_din),
        .data_out (b_dout),
        .hit      (b_hit),
        .ready    (b_ready),
        .busy     (b_busy)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic blk_t pattern_blk(input int unsigned idx);
        blk_t b;
        for (int i = 0; i < BS; i++) begin
            b[i] = 8'(idx * BS + i);
        end
        return b;
    endfunction

    function automatic blk_t fill_blk(input logic [7:0] v);
        blk_t b;
        for (int i = 0; i < BS; i++) begin
            b[i] = v;
        end
        return b;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < BS; i++) begin
            b[i] = 8'($urandom);
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            ref_blk[b] = pattern_blk(b);
        end
        exp_dout = '0;
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic transact_a(input logic rd, input logic wr, input logic [AW-1:0] adr,
                              input blk_t din, input bit scramble, input int hold);
        int n;
        int idx;
        int pulses;
        a_read  = rd;
        a_write = wr;
        a_addr  = adr;
        a_din   = din;
        idx = int'(adr) / BS;
        if (wr) ref_blk[idx] = din;
        if (rd) exp_dout = ref_blk[idx];
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check_eq("busy_after_accept", 256'(a_busy), 256'(1));
                if (scramble) begin
                    a_addr = AW'($urandom);
                    a_din  = rand_blk();
                end
            end
            if (a_ready || n >= 20) break;
        end
        check_eq("ready_latency", 256'(n), 256'(LAT + 1));
        check_eq("hit_with_ready", 256'(a_hit), 256'(1));
        check_eq("data_out", a_dout, exp_dout);
        if (hold > 0) begin
            pulses = 0;
            repeat (hold) begin
                @(negedge clk);
                if (a_ready) pulses++;
            end
            check_eq("hold_extra_ready", 256'(pulses), 256'(0));
            check_eq("hold_busy_wait_rel", 256'(a_busy), 256'(1));
        end
        a_read  = 1'b0;
        a_write = 1'b0;
        @(negedge clk);
        check_eq("ready_dropped", 256'(a_ready), 256'(0));
        check_eq("idle_not_busy", 256'(a_busy), 256'(0));
    endtask

    initial begin
        int n;
        int op;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_eq("reset_ready", 256'(a_ready), 256'(0));
        check_eq("reset_hit", 256'(a_hit), 256'(0));
        check_eq("reset_busy", 256'(a_busy), 256'(0));
        check_eq("reset_data_out", a_dout, 256'(0));

        // Pattern read of block 0x120
        transact_a(1'b1, 1'b0, 11'h123, '0, 1'b0, 0);

        // Write then read back through a different offset; neighbour untouched
        transact_a(1'b0, 1'b1, 11'h040, fill_blk(8'hA5), 1'b0, 0);
        transact_a(1'b1, 1'b0, 11'h05F, '0, 1'b0, 0);
        check_eq("write_readback", a_dout, fill_blk(8'hA5));
        transact_a(1'b1, 1'b0, 11'h060, '0, 1'b0, 0);
        check_eq("neighbour_pattern", a_dout, pattern_blk(3));

        // Held request: one pulse, then accepted right after release
        transact_a(1'b1, 1'b0, 11'h0A0, '0, 1'b0, 10);
        transact_a(1'b1, 1'b0, 11'h0C0, '0, 1'b0, 0);

        // Reset mid-BUSY of a write to the top block
        a_write = 1'b1;
        a_addr  = 11'h7E0;
        a_din   = fill_blk(8'h3C);
        repeat (2) @(negedge clk);
        rst_n   = 1'b0;
        a_write = 1'b0;
        @(negedge clk);
        check_eq("ready_during_reset", 256'(a_ready), 256'(0));
        rst_n = 1'b1;
        model_reset();
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_ready) n++;
        end
        check_eq("no_ready_after_abort", 256'(n), 256'(0));
        check_eq("data_out_cleared", a_dout, 256'(0));
        transact_a(1'b1, 1'b0, 11'h7E0, '0, 1'b0, 0);
        check_eq("top_block_restored", a_dout, pattern_blk(NB - 1));

        // Combined read+write returns the new data
        transact_a(1'b1, 1'b1, 11'h100, fill_blk(8'h5A), 1'b0, 0);
        check_eq("rw_new_data", a_dout, fill_blk(8'h5A));

        // Randomized traffic with inputs scrambled after capture
        for (int t = 0; t < 30; t++) begin
            op = int'($urandom_range(0, 2));
            transact_a(op != 1, op != 0, AW'($urandom), rand_blk(), 1'b1, 0);
        end

        // LATENCY=1 instance: latency and captured address
        b_read = 1'b1;
        b_addr = 11'h000;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n == 1) b_addr = 11'h400;
            if (b_ready || n >= 10) break;
        end
        check_eq("lat1_latency", 256'(n), 256'(2));
        check_eq("lat1_hit", 256'(b_hit), 256'(1));
        check_eq("lat1_captured_addr", b_dout, pattern_blk(0));
        b_read = 1'b0;
        @(negedge clk);
        check_eq("lat1_idle", 256'(b_busy), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
